ofm_writeback_packer: RTL and testbench

- Downstream of the 16-PE convolution sub-top.
- Captures one 16-channel output pixel each time all PE valid bits are asserted, buffers it in a small FIFO, and packs it into four 32-bit words.
- Writes the words into the OFM BRAM in channel-last (HxWxC) layout.
- Tracks pixel and channel-group counters, raises done after the full OFM is written, and flags protocol errors.

---
 rtl/ofm_writeback_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_ofm_writeback_packer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback_packer.sv
// ofm_writeback_packer: captures 16-channel output pixels, buffers them in a small FIFO and
// writes each as four 32-bit words into the OFM BRAM (HxWxC). Optional feature: OFM_RELU_EN.
module ofm_writeback_packer #(
    parameter int NUM_PE     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20,
    parameter int OFM_PIXELS = 2916,
    parameter int CH_TOTAL   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [NUM_PE-1:0]     valid,
    input  logic [NUM_PE*8-1:0]   ofm_in,
    input  logic                  bram_ready,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [31:0]           bram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err_partial
);
    localparam int GROUPS     = CH_TOTAL / 16;
    localparam int PIX_STRIDE = CH_TOTAL / 4;
    localparam int TOTAL_PIX  = OFM_PIXELS * GROUPS;
    localparam int WORDS      = NUM_PE / 4;
    localparam int PIX_W      = NUM_PE * 8;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int P_W        = $clog2(OFM_PIXELS + 1);
    localparam int G_W        = $clog2(GROUPS + 1);
    localparam int T_W        = $clog2(TOTAL_PIX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] pix_addr_reg;
    logic [P_W-1:0]    p_reg;
    logic [G_W-1:0]    g_reg;
    logic [T_W-1:0]    push_cnt_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              out_valid_reg;
    logic [1:0]        out_k_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [31:0]       out_data_reg;
    logic              overflow_reg;
    logic              err_partial_reg;

    logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];

    // Byte conditioning happens ahead of the FIFO so it adds no latency.
    logic [PIX_W-1:0]  pix_in;
    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_byte
`ifdef OFM_RELU_EN
            assign pix_in[8*gi +: 8] = ofm_in[8*gi+7] ? 8'h00 : ofm_in[8*gi +: 8];
`else
            assign pix_in[8*gi +: 8] = ofm_in[8*gi +: 8];
`endif
        end
    endgenerate

    logic              start_acc;
    logic              accept;
    logic              pop;
    logic              capture;
    logic              push;
    logic              drop;
    logic              partial;
    logic              fifo_full;
    logic              last_pixel;
    logic              last_group;
    logic [P_W-1:0]    p_adv;
    logic [G_W-1:0]    g_adv;
    logic [ADDR_W-1:0] pix_addr_adv;

    assign start_acc  = (state_reg == ST_IDLE) && start;
    assign accept     = out_valid_reg && bram_ready;
    assign pop        = accept && (out_k_reg == 2'd3);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign capture    = (state_reg == ST_ACTIVE) && (&valid);
    assign push       = capture && (push_cnt_reg < T_W'(TOTAL_PIX)) && (!fifo_full || pop);
    assign drop       = capture && !push;
    assign partial    = (state_reg == ST_ACTIVE) && (|valid) && !(&valid);
    assign last_pixel = (p_reg == P_W'(OFM_PIXELS - 1));
    assign last_group = (g_reg == G_W'(GROUPS - 1));

    // Pixel/group advance; the group base restarts from base_reg rather than accumulating.
    always_comb begin
        p_adv        = p_reg + P_W'(1);
        g_adv        = g_reg;
        pix_addr_adv = pix_addr_reg + ADDR_W'(PIX_STRIDE);
        if (last_pixel) begin
            p_adv        = '0;
            g_adv        = g_reg + G_W'(1);
            pix_addr_adv = base_reg + ADDR_W'(4 * (int'(g_reg) + 1));
        end
    end

    // When the word in the output register is the head's last word, the next word to
    // present comes from the entry behind the head, so the pop and the load share an edge.
    logic              ld_from_next;
    logic              ld_avail;
    logic              do_load;
    logic [PTR_W-1:0]  ld_ptr;
    logic [1:0]        ld_k;
    logic [ADDR_W-1:0] ld_pix_addr;
    logic [PIX_W-1:0]  ld_entry;
    logic [WORDS-1:0][31:0] ld_words;

    assign ld_from_next = out_valid_reg && (out_k_reg == 2'd3);
    assign ld_avail     = ld_from_next ? (count_reg > CNT_W'(1)) : (count_reg != '0);
    assign ld_ptr       = ld_from_next ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
    assign ld_k         = out_valid_reg ? (out_k_reg + 2'd1) : 2'd0;
    assign ld_pix_addr  = ld_from_next ? pix_addr_adv : pix_addr_reg;
    assign do_load      = (state_reg == ST_ACTIVE) && (!out_valid_reg || bram_ready) && ld_avail;
    assign ld_entry     = fifo_mem[ld_ptr];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            for (genvar gj = 0; gj < 4; gj++) begin : g_lane
                assign ld_words[gi][31-8*gj -: 8] = ld_entry[8*(4*gi+gj) +: 8];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_ACTIVE;
            ST_ACTIVE: if (pop && last_pixel && last_group) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_reg        <= '0;
            pix_addr_reg    <= '0;
            p_reg           <= '0;
            g_reg           <= '0;
            push_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_k_reg       <= 2'd0;
            out_addr_reg    <= '0;
            out_data_reg    <= '0;
            overflow_reg    <= 1'b0;
            err_partial_reg <= 1'b0;
        end else if (start_acc) begin
            base_reg        <= base_addr;
            pix_addr_reg    <= base_addr;
            p_reg           <= '0;
            g_reg           <= '0;
            push_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_k_reg       <= 2'd0;
            overflow_reg    <= 1'b0;
            err_partial_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                push_cnt_reg <= push_cnt_reg + T_W'(1);
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                p_reg        <= p_adv;
                g_reg        <= g_adv;
                pix_addr_reg <= pix_addr_adv;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (partial) begin
                err_partial_reg <= 1'b1;
            end
            if (do_load) begin
                out_valid_reg <= 1'b1;
                out_k_reg     <= ld_k;
                out_addr_reg  <= ld_pix_addr + ADDR_W'(ld_k);
                out_data_reg  <= ld_words[ld_k];
            end else if (accept) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bram_we     = out_valid_reg;
    assign bram_addr   = out_addr_reg;
    assign bram_wdata  = out_data_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign overflow    = overflow_reg;
    assign err_partial = err_partial_reg;

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Self-checking bench for ofm_writeback_packer: directed steps with random pixel data and
// backpressure, checked against a word-level queue model built from the addressing rules.
module tb_ofm_writeback_packer;
    localparam int NUM_PE     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 20;
    localparam int OFM_PIXELS = 4;
    localparam int CH_TOTAL   = 32;
    localparam int TOTAL_PIX  = OFM_PIXELS * (CH_TOTAL / 16);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [NUM_PE-1:0]   valid;
    logic [NUM_PE*8-1:0] ofm_in;
    logic                bram_ready;
    logic                bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [31:0]         bram_wdata;
    logic                busy;
    logic                done;
    logic                overflow;
    logic                err_partial;

    always #5 clk = ~clk;

    ofm_writeback_packer #(
        .NUM_PE(NUM_PE), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W),
        .OFM_PIXELS(OFM_PIXELS), .CH_TOTAL(CH_TOTAL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .valid(valid), .ofm_in(ofm_in), .bram_ready(bram_ready),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .busy(busy), .done(done), .overflow(overflow), .err_partial(err_partial)
    );

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    logic [31:0]       exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [ADDR_W-1:0] base_model;
    int                pushed_run;
    int                writes_seen;
    int                done_seen;
    bit                run_active;
    bit                exp_overflow;
    bit                exp_err;
    bit                done_due;
    bit                stall_prev;
    logic [ADDR_W-1:0] stall_addr;
    logic [31:0]       stall_data;
    logic [ADDR_W-1:0] addr_log[64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef OFM_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    // Pixel n of a run lands at base + p*(CH_TOTAL/4) + g*4 + k, p = n mod H*W, g = n div H*W.
    task automatic model_push();
        int unsigned p, g, a;
        logic [31:0] w;
        p = pushed_run % OFM_PIXELS;
        g = pushed_run / OFM_PIXELS;
        for (int k = 0; k < 4; k++) begin
            w = {relu(ofm_in[8*(4*k) +: 8]), relu(ofm_in[8*(4*k+1) +: 8]),
                 relu(ofm_in[8*(4*k+2) +: 8]), relu(ofm_in[8*(4*k+3) +: 8])};
            a = (int'(base_model) + p * (CH_TOTAL / 4) + g * 4 + k) % (1 << ADDR_W);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(w);
        end
        pushed_run++;
    endtask

    task automatic tick();
        bit acc, pop_now, cap_active;
        int outstanding;
        @(negedge clk);
        if (!reset) begin
            check("done_pulse", 32'(done), 32'(done_due));
            done_due = 1'b0;
            if (done) done_seen++;
            if (stall_prev) begin
                check("hold_we", 32'(bram_we), 32'd1);
                check("hold_addr", 32'(bram_addr), 32'(stall_addr));
                check("hold_data", bram_wdata, stall_data);
            end
            stall_prev  = bram_we && !bram_ready;
            stall_addr  = bram_addr;
            stall_data  = bram_wdata;
            acc         = bram_we && bram_ready;
            outstanding = pushed_run - writes_seen / 4;
            cap_active  = run_active;
            pop_now     = 1'b0;
            if (acc) begin
                check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("wr_addr", 32'(bram_addr), exp_addr_q.pop_front());
                    check("wr_data", bram_wdata, exp_data_q.pop_front());
                end
                if (writes_seen < 64) addr_log[writes_seen] = bram_addr;
                writes_seen++;
                pop_now = (writes_seen % 4 == 0);
                if (run_active && writes_seen == 4 * TOTAL_PIX) begin
                    run_active = 1'b0;
                    done_due   = 1'b1;
                end
            end
            if (cap_active && valid === '1) begin
                if (pushed_run < TOTAL_PIX && (outstanding < FIFO_DEPTH || pop_now)) model_push();
                else exp_overflow = 1'b1;
            end else if (cap_active && valid != '0) begin
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        pushed_run   = 0;
        writes_seen  = 0;
        done_seen    = 0;
        run_active   = 1'b0;
        exp_overflow = 1'b0;
        exp_err      = 1'b0;
        done_due     = 1'b0;
        stall_prev   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; valid = '0; bram_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        clear_model();
        base_model = base;
        run_active = 1'b1;
    endtask

    task automatic rand_pixel();
        for (int i = 0; i < NUM_PE; i++) ofm_in[8*i +: 8] = 8'($urandom);
    endtask

    task automatic capture();
        valid = '1;
        tick();
        valid = '0;
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int n = 0;
        while (exp_addr_q.size() != 0 && n < budget) begin
            bram_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_space(input int budget);
        int n = 0;
        while ((pushed_run - writes_seen / 4) >= FIFO_DEPTH && n < budget) begin
            bram_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("space_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; valid = '0; ofm_in = '0; bram_ready = 1'b0;
        clear_model();
        do_reset();
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_wdata", bram_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_err", 32'(err_partial), 32'd0);

        // Single directed pixel, first word one cycle after capture.
        do_start(20'h100);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < NUM_PE; i++) ofm_in[8*i +: 8] = 8'(i);
        bram_ready = 1'b0;
        capture();
        tick();
        check("first_we", 32'(bram_we), 32'd1);
        check("first_addr", 32'(bram_addr), 32'h100);
        check("first_data", bram_wdata, 32'h00010203);
        drain(50, 1'b0);
        tick();
        tick();
        check("single_writes", 32'(writes_seen), 32'd4);

        // Backpressure on word 1, with the address wrapping past 2^ADDR_W.
        do_reset();
        do_start(20'hFFFFE);
        rand_pixel();
        bram_ready = 1'b1;
        capture();
        for (int n = 0; n < 20 && writes_seen < 1; n++) tick();
        bram_ready = 1'b0;
        repeat (10) tick();
        check("bp_no_advance", 32'(writes_seen), 32'd1);
        check("bp_we", 32'(bram_we), 32'd1);
        drain(50, 1'b0);
        tick();
        check("bp_writes", 32'(writes_seen), 32'd4);

        // Overflow: five captures into a four-deep FIFO that cannot drain.
        do_reset();
        do_start(20'($urandom));
        bram_ready = 1'b0;
        repeat (5) begin
            rand_pixel();
            capture();
        end
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_model", 32'(overflow), 32'(exp_overflow));
        drain(100, 1'b0);
        repeat (3) tick();
        check("ovf_writes", 32'(writes_seen), 32'd16);

        // Partial valid, then a full run with random backpressure and one late capture.
        do_reset();
        do_start(20'h0);
        rand_pixel();
        valid = 16'h00FF;
        tick();
        valid = '0;
        tick();
        check("partial_err", 32'(err_partial), 32'(exp_err));
        check("partial_no_we", 32'(bram_we), 32'd0);
        check("partial_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < TOTAL_PIX; i++) begin
            wait_space(200);
            rand_pixel();
            capture();
        end
        rand_pixel();
        capture();
        tick();
        check("late_capture_ovf", 32'(overflow), 32'(exp_overflow));
        drain(300, 1'b1);
        bram_ready = 1'b1;
        repeat (3) tick();
        check("run_writes", 32'(writes_seen), 32'(4 * TOTAL_PIX));
        check("done_once", 32'(done_seen), 32'd1);
        check("busy_fell", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) check("g1p2_addr", 32'(addr_log[24 + k]), 32'(20 + k));
        check("err_sticky", 32'(err_partial), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_start(20'($urandom));
        check("start_clr_err", 32'(err_partial), 32'd0);
        check("start_clr_ovf", 32'(overflow), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // Reset in the middle of a pixel, then confirm counters restart at zero.
        bram_ready = 1'b0;
        rand_pixel();
        capture();
        tick();
        check("mid_we_before", 32'(bram_we), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_we", 32'(bram_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        clear_model();
        do_start(20'h0);
        rand_pixel();
        ofm_in[7:0]  = 8'h80;
        ofm_in[15:8] = 8'h7F;
        bram_ready = 1'b1;
        capture();
        drain(50, 1'b0);
        tick();
        check("post_rst_writes", 32'(writes_seen), 32'd4);
        check("post_rst_addr0", 32'(addr_log[0]), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
